// File: rtl/sreg_batch_seq.sv
// Moves a contiguous GPR range to or from the snapshot regfile in beats of up to CHUNK registers.
// Beats issue one per cycle from the cycle after accept; each beat stalls until sreg_ack_i; done_o pulses for one cycle after the last beat.
module sreg_batch_seq #(
  parameter int CHUNK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_op_i,
  input  logic [4:0]            cmd_start_i,
  input  logic [5:0]            cmd_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CHUNK*5-1:0]    gpr_raddr_o,
  input  logic [CHUNK*32-1:0]   gpr_rdata_i,
  output logic [CHUNK-1:0]      gpr_we_o,
  output logic [CHUNK*5-1:0]    gpr_waddr_o,
  output logic [CHUNK*32-1:0]   gpr_wdata_o,
  output logic                  sreg_req_o,
  output logic [6:0]            sreg_funct7_o,
  output logic [4:0]            sreg_batch_start_o,
  output logic [4:0]            sreg_batch_len_o,
  output logic [CHUNK*32-1:0]   sreg_rs_val_o,
  input  logic                  sreg_ack_i,
  input  logic                  sreg_error_i,
  input  logic [CHUNK*32-1:0]   sreg_rd_val_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SAVE = 2'd1;
  localparam logic [1:0] S_REST = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [5:0] cur_q, cur_d;
  logic [5:0] rem_q, rem_d;
  logic       err_q, err_d;

  logic [5:0] blen;
  logic [6:0] end_sum;
  logic       in_beat;
  logic [5:0] lane_addr;
  logic       lane_act;

  assign blen    = (rem_q < 6'(CHUNK)) ? rem_q : 6'(CHUNK);
  assign end_sum = {2'b00, cmd_start_i} + {1'b0, cmd_len_i};
  assign in_beat = (state_q == S_SAVE) || (state_q == S_REST);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cur_d = {1'b0, cmd_start_i};
          rem_d = cmd_len_i;
          // Reject empty or out-of-range commands before any beat is issued.
          if (cmd_len_i == 6'd0 || end_sum > 7'd32) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            state_d = cmd_op_i ? S_REST : S_SAVE;
          end
        end
      end
      S_SAVE, S_REST: begin
        if (sreg_ack_i) begin
          if (sreg_error_i) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            cur_d = cur_q + blen;
            rem_d = rem_q - blen;
            if (rem_q == blen) begin
              err_d   = 1'b0;
              state_d = S_FIN;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cur_q   <= 6'd0;
      rem_q   <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o        = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = (state_q == S_FIN);
  assign err_o              = (state_q == S_FIN) && err_q;
  assign sreg_req_o         = in_beat;
  assign sreg_funct7_o      = (state_q == S_REST) ? 7'h40 : 7'h00;
  assign sreg_batch_start_o = in_beat ? cur_q[4:0] : 5'd0;
  assign sreg_batch_len_o   = in_beat ? blen[4:0] : 5'd0;

  // Lanes beyond the beat length stay fully quiet so the regfile sees zeros.
  always_comb begin
    gpr_raddr_o   = '0;
    gpr_we_o      = '0;
    gpr_waddr_o   = '0;
    gpr_wdata_o   = '0;
    sreg_rs_val_o = '0;
    lane_addr     = 6'd0;
    lane_act      = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      lane_addr = cur_q + 6'(k);
      lane_act  = in_beat && (6'(k) < blen);
      if (lane_act && state_q == S_SAVE) begin
        gpr_raddr_o[5*k +: 5]    = lane_addr[4:0];
        sreg_rs_val_o[32*k +: 32] = gpr_rdata_i[32*k +: 32];
      end
      if (lane_act && state_q == S_REST) begin
        gpr_waddr_o[5*k +: 5]   = lane_addr[4:0];
        gpr_wdata_o[32*k +: 32] = sreg_rd_val_i[32*k +: 32];
        gpr_we_o[k]             = sreg_ack_i && !sreg_error_i && (lane_addr != 6'd0);
      end
    end
  end

endmodule
